// File: rtl/status_frame_tx.sv
// rtl/status_frame_tx.sv - status record to byte-stream frame serialiser (optional STATUS_FRAME_CHKSUM_EN)
//
// Accepts one (code, payload) record per req handshake and emits it MSB-first as
// a frame of bytes: code, payload[PL_BYTES-1] .. payload[0], and optionally an
// XOR checksum byte when STATUS_FRAME_CHKSUM_EN is defined.

module status_frame_tx #(
    parameter int PL_BYTES = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [7:0]            req_code,
    input  logic [8*PL_BYTES-1:0] req_pl,
    output logic [7:0]            axis_tdata,
    output logic                  axis_tvalid,
    input  logic                  axis_tready,
    output logic                  axis_tlast,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    // Byte index needs at least one bit even for single-byte payloads.
    localparam int IDX_W = (PL_BYTES > 1) ? $clog2(PL_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PL_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CODE    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
`ifdef STATUS_FRAME_CHKSUM_EN
    localparam logic [1:0] ST_CHKSUM  = 2'd3;
`endif

    logic [1:0]            state_q, state_d;
    logic [7:0]            code_q, code_d;
    logic [8*PL_BYTES-1:0] pl_q, pl_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           cnt_q, cnt_d;
`ifdef STATUS_FRAME_CHKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    logic       accept;
    logic       beat;
    logic [7:0] pl_byte;

`ifdef STATUS_FRAME_CHKSUM_EN
    // Checksum over code plus every payload byte, computed once at acceptance
    // so the serialiser only has to replay a latched byte.
    function automatic logic [7:0] frame_xor(input logic [7:0] c,
                                             input logic [8*PL_BYTES-1:0] p);
        logic [7:0] acc;
        acc = c;
        for (int i = 0; i < PL_BYTES; i++) begin
            acc = acc ^ p[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // Ready is derived from state only; reset holds it low.
    assign req_rdy     = (state_q == ST_IDLE) && !rst;
    assign accept      = req_vld && req_rdy;
    assign axis_tvalid = (state_q != ST_IDLE);
    assign beat        = axis_tvalid && axis_tready;
    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = cnt_q;

    // Select the latched payload byte addressed by the current index.
    always_comb begin
        pl_byte = 8'h00;
        for (int i = 0; i < PL_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pl_byte = pl_q[8*i +: 8];
            end
        end
    end

    // Frame sequencing: latch the record, then walk code, payload, checksum.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pl_d    = pl_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef STATUS_FRAME_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d  = req_code;
                    pl_d    = req_pl;
                    idx_d   = IDX_LAST;
`ifdef STATUS_FRAME_CHKSUM_EN
                    chk_d   = frame_xor(req_code, req_pl);
`endif
                    state_d = ST_CODE;
                end
            end
            ST_CODE: begin
                if (beat) begin
                    idx_d   = IDX_LAST;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (beat) begin
                    if (idx_q == IDX_ZERO) begin
`ifdef STATUS_FRAME_CHKSUM_EN
                        state_d = ST_CHKSUM;
`else
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q + 16'd1;
`endif
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
`ifdef STATUS_FRAME_CHKSUM_EN
            ST_CHKSUM: begin
                if (beat) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output byte and end-of-frame marker, both pure functions of held state
    // so they stay stable under backpressure.
    always_comb begin
        axis_tdata = 8'h00;
        axis_tlast = 1'b0;
        case (state_q)
            ST_CODE: begin
                axis_tdata = code_q;
            end
            ST_PAYLOAD: begin
                axis_tdata = pl_byte;
`ifndef STATUS_FRAME_CHKSUM_EN
                axis_tlast = (idx_q == IDX_ZERO);
`endif
            end
`ifdef STATUS_FRAME_CHKSUM_EN
            ST_CHKSUM: begin
                axis_tdata = chk_q;
                axis_tlast = 1'b1;
            end
`endif
            default: begin
                axis_tdata = 8'h00;
                axis_tlast = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight and clears the count.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= 8'h00;
            pl_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= 16'h0000;
`ifdef STATUS_FRAME_CHKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pl_q    <= pl_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
`ifdef STATUS_FRAME_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

endmodule
